// File: rtl/aes_gf_inverter_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_gf_inverter_if
// Description : Handshake and data bundle for the AES composite-field
//               inverter. The slave modport is the inverter's view; the
//               master modport is the view of whoever drives operands and
//               consumes results.
//               flush_i            synchronous pipeline flush
//               valid_i/ready_o    operand handshake, operand_i[7:0]
//               valid_o/ready_i    result handshake, inverse_o[7:0]
//               count_o[15:0]      completed-transfer count, present only
//                                  when AES_INV_PERF_CNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_gf_inverter_if;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  operand_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  inverse_o;
`ifdef AES_INV_PERF_CNT_EN
    logic [15:0] count_o;
`endif

    modport slave (
        input  flush_i, valid_i, operand_i, ready_i,
        output ready_o, valid_o, inverse_o
`ifdef AES_INV_PERF_CNT_EN
        , output count_o
`endif
    );

    modport master (
        output flush_i, valid_i, operand_i, ready_i,
        input  ready_o, valid_o, inverse_o
`ifdef AES_INV_PERF_CNT_EN
        , input  count_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/aes_gf_inverter.sv
`default_nettype none
// ============================================================================
// Module      : aes_gf_inverter
// Description : Three-stage pipelined multiplicative inverter for the AES
//               composite field GF((2^4)^2). GF(2^4) uses x^4+x+1 and the
//               extension uses y^2+y+lambda with lambda = 4'hC.
//               Ports: clk_i  - clock, rising edge
//                      rst_i  - synchronous active-high reset
//                      bus    - aes_gf_inverter_if.slave (operand/result
//                               handshakes, flush, optional count)
//               Optional feature macro: AES_INV_PERF_CNT_EN adds a 16-bit
//               saturating count of output transfers on bus.count_o.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_gf_inverter (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    aes_gf_inverter_if.slave bus
);

    localparam logic [3:0] C_LAMBDA = 4'hC;

    // GF(2^4) multiply, shift-and-add with reduction by x^4 = x + 1.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Squaring is linear in GF(2^4), so it reduces to a few XORs.
    function automatic logic [3:0] gf4_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    // GF(2^4) inverse as a table; zero maps to zero.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Valid bits
    logic       r_v1, r_v2, r_v3;
    // Stage data (no reset needed: qualified by the valid bits)
    logic [3:0] r_ah1, r_al1, r_d1;
    logic [3:0] r_ah2, r_al2, r_dinv2;
    logic [7:0] r_inv3;

    logic       w_adv;
    logic [3:0] w_ah, w_al, w_d;

    // The whole pipeline advances unless the output is held by backpressure.
    assign w_adv = !r_v3 || bus.ready_i;

    assign w_ah = bus.operand_i[7:4];
    assign w_al = bus.operand_i[3:0];
    assign w_d  = gf4_mul(C_LAMBDA, gf4_sq(w_ah)) ^ gf4_mul(w_ah, w_al) ^ gf4_sq(w_al);

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= bus.valid_i;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_adv) begin
            r_ah1   <= w_ah;
            r_al1   <= w_al;
            r_d1    <= w_d;
            r_ah2   <= r_ah1;
            r_al2   <= r_al1;
            r_dinv2 <= gf4_inv(r_d1);
            r_inv3  <= {gf4_mul(r_ah2, r_dinv2), gf4_mul(r_ah2 ^ r_al2, r_dinv2)};
        end
    end

    assign bus.ready_o   = w_adv;
    assign bus.valid_o   = r_v3;
    assign bus.inverse_o = r_inv3;

`ifdef AES_INV_PERF_CNT_EN
    logic [15:0] r_count;

    // Counts output transfers, saturating; flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 16'h0000;
        end else if (r_v3 && bus.ready_i && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'h0001;
        end
    end

    assign bus.count_o = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_gf_inverter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_gf_inverter
// Description : Scoreboard bench for aes_gf_inverter. Expected inverses come
//               from a brute-force search over the composite-field product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_gf_inverter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    aes_gf_inverter_if bus();

    aes_gf_inverter u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] op;
        logic [7:0] exp;
        logic [7:0] orig;
        int         cyc;
    } sb_entry_t;

    sb_entry_t  sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] inv_tab [256];
    logic [7:0] outs    [256];
    logic [7:0] cur_orig = 8'h00;
    int         phase    = 0;
    bit         chk_lat  = 0;
    bit         rand_rdy = 0;
    bit         hold_valid = 0;
    logic [7:0] hold_data  = 8'h00;
    int         model_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // GF(2^4): carry-less product then reduction by 0x13.
    function automatic logic [3:0] g4(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = 7'h00;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
        for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (7'(7'b0010011) << (k - 4));
        return p[3:0];
    endfunction

    // Composite product: y^2 = y + 4'hC.
    function automatic logic [7:0] cmul(input logic [7:0] x, input logic [7:0] z);
        logic [3:0] hh, hi, lo;
        hh = g4(x[7:4], z[7:4]);
        hi = hh ^ g4(x[7:4], z[3:0]) ^ g4(x[3:0], z[7:4]);
        lo = g4(hh, 4'hC) ^ g4(x[3:0], z[3:0]);
        return {hi, lo};
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: handshakes are sampled mid-cycle, i.e. the values the next edge sees.
    always @(negedge clk_i) begin
        if (rst_i) begin
            sb.delete();
            hold_valid  = 0;
            model_count = 0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", 32'(bus.valid_o), 32'd1);
                check("stall_data", 32'(bus.inverse_o), 32'(hold_data));
            end
            if (bus.valid_o && !bus.ready_i)
                check("stall_ready", 32'(bus.ready_o), 32'd0);
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(bus.inverse_o), 32'hFFFF_FFFF);
                end else begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check("inverse", 32'(bus.inverse_o), 32'(e.exp));
                    if (e.op != 8'h00)
                        check("product", 32'(cmul(bus.inverse_o, e.op)), 32'h01);
                    if (e.op == 8'h10) check("kat_10", 32'(bus.inverse_o), 32'hAA);
                    if (e.op == 8'h02) check("kat_02", 32'(bus.inverse_o), 32'h09);
                    if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
                    if (phase == 1) outs[e.orig] = bus.inverse_o;
                    if (phase == 2) check("inv_inv", 32'(bus.inverse_o), 32'(e.orig));
                    if (model_count < 65535) model_count++;
                end
            end
            if (bus.flush_i) begin
                sb.delete();
            end else if (bus.valid_i && bus.ready_o) begin
                sb.push_back('{op: bus.operand_i, exp: inv_tab[bus.operand_i],
                               orig: cur_orig, cyc: cyc});
            end
            hold_valid = bus.valid_o && !bus.ready_i && !bus.flush_i;
            hold_data  = bus.inverse_o;
        end
    end

    task automatic send(input logic [7:0] op);
        int  n;
        logic acc;
        n = 0;
        bus.valid_i   = 1'b1;
        bus.operand_i = op;
        do begin
            @(negedge clk_i);
            acc = bus.ready_o && !bus.flush_i;
            @(posedge clk_i);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.valid_o) && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check("rst_ready_o", 32'(bus.ready_o), 32'd1);
`ifdef AES_INV_PERF_CNT_EN
        check("rst_count", 32'(bus.count_o), 32'd0);
`endif
        rst_i = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int b = 1; b < 256; b++)
                if (cmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
        end
        bus.flush_i   = 1'b0;
        bus.valid_i   = 1'b0;
        bus.operand_i = 8'h00;
        bus.ready_i   = 1'b1;
        @(posedge clk_i);
        #1;
        do_reset();

        // Single op and back-to-back known answers, latency checked.
        chk_lat = 1;
        send(8'h10);
        drain();
        send(8'h00);
        send(8'h01);
        send(8'h02);
        drain();

        // Backpressure: four ops, stall 5 cycles once the first result shows.
        chk_lat = 0;
        fork
            begin
                send(8'h53);
                send(8'hCA);
                send(8'hFF);
                send(8'h7E);
            end
            begin
                int n;
                n = 0;
                while (!bus.valid_o && n < 20) begin
                    @(posedge clk_i);
                    #1;
                    n++;
                end
                if (!bus.valid_o) check("bp_wait_timeout", 32'd0, 32'd1);
                bus.ready_i = 1'b0;
                repeat (5) @(posedge clk_i);
                #1;
                bus.ready_i = 1'b1;
            end
        join
        drain();

        // Flush with three ops in flight; an op offered during flush is discarded.
        bus.ready_i = 1'b0;
        send(8'h21);
        send(8'h43);
        send(8'h65);
        bus.flush_i   = 1'b1;
        bus.valid_i   = 1'b1;
        bus.operand_i = 8'h99;
        @(posedge clk_i);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        check("flush_valid_o", 32'(bus.valid_o), 32'd0);
        bus.ready_i = 1'b1;
        chk_lat = 1;
        send(8'h87);
        drain();
        chk_lat = 0;

        // Reset mid-operation drops in-flight work.
        bus.ready_i = 1'b0;
        send(8'h3C);
        send(8'h4D);
        do_reset();
        bus.ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("post_rst_idle", 32'(bus.valid_o), 32'd0);

        // Exhaustive sweep, then feed every result back in.
        rand_rdy = 1;
        fork
            while (rand_rdy) begin
                @(posedge clk_i);
                #1;
                bus.ready_i = ($urandom_range(0, 3) != 0);
            end
        join_none
        phase = 1;
        for (int a = 0; a < 256; a++) begin
            cur_orig = 8'(a);
            send(8'(a));
        end
        drain();
        phase = 2;
        for (int a = 0; a < 256; a++) begin
            cur_orig = 8'(a);
            send(outs[a]);
        end
        drain();
        phase = 0;
        rand_rdy = 0;
        @(posedge clk_i);
        #2;
        bus.ready_i = 1'b1;
        drain();

`ifdef AES_INV_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 10; i++) send(8'(i * 17 + 3));
        drain();
        check("count_model", 32'(bus.count_o), 32'(model_count));
        check("count_10", 32'(bus.count_o), 32'd10);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_gf_inverter.md
AES_GF_INVERTER -- requirements
Module: aes_gf_inverter

Interface
REQ-001 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have port flush_i, input, 1 bit: synchronous pipeline flush.
REQ-004 The module SHALL have port valid_i, input, 1 bit: the operand is valid.
REQ-005 The module SHALL have port ready_o, output, 1 bit: the block accepts an operand this cycle.
REQ-006 The module SHALL have port operand_i, input, 8 bits: the composite-field element; [7:4]=ah, [3:0]=al.
REQ-007 The module SHALL have port valid_o, output, 1 bit: the result is valid.
REQ-008 The module SHALL have port ready_i, input, 1 bit: downstream accepts the result.
REQ-009 The module SHALL have port inverse_o, output, 8 bits: the composite-field inverse; [7:4]=bh, [3:0]=bl.
REQ-010 The module SHALL have port count_o, output, 16 bits: the completed-transfer count; it is present only under AES_INV_PERF_CNT_EN.

Function
REQ-011 Arithmetic SHALL be in GF(2^4) with polynomial x^4+x+1, extended to GF(2^8) by y^2+y+lambda, where lambda=4'hC.
REQ-012 GF(2^4) squaring SHALL be: q3=a3, q2=a3^a1, q1=a2, q0=a2^a0.
REQ-013 Stage 1 SHALL register ah, al and d = lambda*ah^2 ^ ah*al ^ al^2.
REQ-014 Stage 2 SHALL register ah, al and d' = d^-1 in GF(2^4), with 0^-1 defined as 0.
REQ-015 Stage 3 SHALL register bh = ah*d' and bl = (ah^al)*d' into inverse_o.
REQ-016 Latency from an accepted input to valid_o SHALL be exactly 3 cycles when not stalled.
REQ-017 The pipeline SHALL have a global enable adv = !valid_o | ready_i, and ready_o SHALL equal adv.
REQ-018 Handshake and stall behaviour:
- A transfer SHALL occur on a cycle with valid_i & ready_o, or with valid_o & ready_i.
- When adv=0, all stage registers SHALL hold.
- valid_o and inverse_o SHALL stay stable until ready_i.
REQ-019 Per-stage valid bits SHALL shift on adv, so bubbles propagate and full throughput is 1 result per cycle.
REQ-020 Input 8'h00 SHALL produce 8'h00, with no special-case error.
REQ-021 flush_i=1 SHALL clear all stage valid bits on the next edge, override adv, and discard any input offered that cycle.
REQ-022 rst_i SHALL take priority over flush_i.
REQ-023 Stage data registers SHALL need no reset; only the valid bits and the counter are reset.

Reset
REQ-024 On rst_i=1 at a clock edge, all stage valid bits SHALL be cleared, so valid_o=0.
REQ-025 Under reset, count_o SHALL be 0 and ready_o SHALL be 1 in the following cycle.
REQ-026 Reset mid-operation SHALL drop all in-flight results with no output transfer.
REQ-027 Following reset, inverse_o SHALL be don't-care while valid_o=0.

Configuration
REQ-028 With macro AES_INV_PERF_CNT_EN defined:
- count_o SHALL increment by 1 on each output transfer (valid_o & ready_i).
- count_o SHALL saturate at 16'hFFFF.
- flush_i SHALL not clear count_o.
REQ-029 Without AES_INV_PERF_CNT_EN, port count_o and its register SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-030 Reset then single op: operand 8'h10, ready_i=1 -> valid_o at cycle 3, inverse_o=8'hAA.
REQ-031 Back-to-back 8'h00, 8'h01, 8'h02 with ready_i=1 -> 8'h00, 8'h01, 8'h09 on 3 consecutive cycles.
REQ-032 Backpressure:
- Stimulus: stream 4 operands and hold ready_i=0 for 5 cycles once valid_o rises.
- Required response: ready_o=0 while stalled, inverse_o stable, all 4 results delivered in order with none lost or duplicated.
REQ-033 Flush: assert flush_i with 3 ops in flight -> valid_o=0 on the next cycle, and a following op returns its result 3 cycles after acceptance.
REQ-034 Exhaustive: all 256 operands -> bh:bl times ah:al = 8'h01 in the composite field for every nonzero input, and inv(inv(a))=a.
REQ-035 Under AES_INV_PERF_CNT_EN, 10 transfers then rst_i -> count_o=10, then 0.
